mem_arbiter: RTL and testbench

// Two-port arbiter/sequencer in front of the single-transaction memory block (SRAM/SPI, I2C, UART, control regs).

---
 rtl/mem_pkg.sv | 31 +++
 rtl/arb_rr2.sv | 28 ++
 rtl/mem_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the memory arbiter and memory block.
// No ports: FSM states, port ids, RV funct3 codes, memory map.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    WAIT,
    RELEASE
  } arb_state_t;

  typedef enum logic {
    PORT_I,
    PORT_D
  } port_t;

  localparam logic [2:0] FUNCT3_B  = 3'b000;
  localparam logic [2:0] FUNCT3_H  = 3'b001;
  localparam logic [2:0] FUNCT3_W  = 3'b010;
  localparam logic [2:0] FUNCT3_BU = 3'b100;
  localparam logic [2:0] FUNCT3_HU = 3'b101;
  localparam logic [2:0] FUNCT3_LW = FUNCT3_W;

  localparam logic [31:0] SRAM_BASE = 32'h0000_0000;
  localparam logic [31:0] GPIO_ADDR = 32'h0080_0000;
  localparam logic [31:0] SPI_BASE  = 32'h0081_0000;
  localparam logic [31:0] I2C_BASE  = 32'h0082_0000;
  localparam logic [31:0] UART_BASE = 32'h0083_0000;
  localparam logic [31:0] CTRL_BASE = 32'h0084_0000;

endpackage

// File: rtl/arb_rr2.sv
// Two-way grant for fetch (I) and load/store (D) requests.
// In: req_i, req_d, last_grant. Out: one-hot gnt_i / gnt_d (combinational).
module arb_rr2
  import mem_pkg::*;
#(
  parameter int D_PRIORITY = 1
) (
  input  logic  req_i,
  input  logic  req_d,
  input  port_t last_grant,
  output logic  gnt_i,
  output logic  gnt_d
);

  logic tie_d;

  // With only two ports, D-preferred round-robin and
  // strict alternation both hand a tie to the port not served last.
  always_comb begin
    if (D_PRIORITY != 0)
      tie_d = (last_grant != PORT_D);
    else
      tie_d = (last_grant == PORT_I);
    gnt_d = req_d & (~req_i | tie_d);
    gnt_i = req_i & ~gnt_d;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Sequencer sharing one memory block between fetch (I) and LSU (D), with watchdog.
// Ports: I/D request+response channels, registered mem_* request, mem_* status in.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int D_PRIORITY     = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ready,
  output logic        i_rsp_valid,
  output logic [31:0] i_rdata,
  output logic        i_fault,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [2:0]  d_funct3,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic        d_rsp_valid,
  output logic [31:0] d_rdata,
  output logic        d_fault,
  output logic        d_timeout,
  output logic        mem_ce,
  output logic [2:0]  mem_funct3,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_datain,
  output logic        mem_memwrite,
  input  logic [31:0] mem_dataout,
  input  logic        mem_busy,
  input  logic        mem_valid,
  input  logic        mem_fault
);

  localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT_CYCLES);
  localparam bit          WD_ON    = (TIMEOUT_CYCLES != 0);

  arb_state_t  state;
  port_t       last_grant;
  logic [15:0] wd_cnt;
  logic [15:0] wd_nxt;
  logic        wd_hit;
  logic        gnt_i;
  logic        gnt_d;
  logic        done;
  logic        r_fault;
  logic        r_to;
  logic [31:0] r_data;

  arb_rr2 #(
    .D_PRIORITY(D_PRIORITY)
  ) u_rr (
    .req_i     (i_req),
    .req_d     (d_req),
    .last_grant(last_grant),
    .gnt_i     (gnt_i),
    .gnt_d     (gnt_d)
  );

  // Fault, valid and store-done all end the access; a read
  // never ends on busy falling alone.
  always_comb begin
    wd_nxt  = (&wd_cnt) ? wd_cnt : wd_cnt + 16'd1;
    wd_hit  = WD_ON && (wd_nxt == WD_LIMIT);
    done    = mem_fault | mem_valid
            | (~mem_busy & mem_memwrite);
    r_fault = done ? mem_fault : 1'b1;
    r_data  = done ? mem_dataout : 32'd0;
    r_to    = ~done;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      last_grant   <= PORT_I;
      wd_cnt       <= '0;
      mem_ce       <= 1'b1;
      mem_funct3   <= '0;
      mem_addr     <= '0;
      mem_datain   <= '0;
      mem_memwrite <= 1'b0;
      i_ready      <= 1'b0;
      i_rsp_valid  <= 1'b0;
      i_rdata      <= '0;
      i_fault      <= 1'b0;
      d_ready      <= 1'b0;
      d_rsp_valid  <= 1'b0;
      d_rdata      <= '0;
      d_fault      <= 1'b0;
      d_timeout    <= 1'b0;
    end else begin
      i_ready     <= 1'b0;
      i_rsp_valid <= 1'b0;
      i_fault     <= 1'b0;
      d_ready     <= 1'b0;
      d_rsp_valid <= 1'b0;
      d_fault     <= 1'b0;
      d_timeout   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (gnt_i | gnt_d) begin
            last_grant   <= gnt_d ? PORT_D : PORT_I;
            mem_funct3   <= gnt_d ? d_funct3 : FUNCT3_LW;
            mem_addr     <= gnt_d ? d_addr : i_addr;
            mem_datain   <= gnt_d ? d_wdata : 32'd0;
            mem_memwrite <= gnt_d & d_we;
            i_ready      <= gnt_i;
            d_ready      <= gnt_d;
            mem_ce       <= 1'b0;
            state        <= ARM;
          end
        end
        ARM: begin
          wd_cnt <= '0;
          state  <= WAIT;
        end
        WAIT: begin
          if (done | wd_hit) begin
            if (last_grant == PORT_D) begin
              d_rsp_valid <= 1'b1;
              d_fault     <= r_fault;
              d_rdata     <= r_data;
            end else begin
              i_rsp_valid <= 1'b1;
              i_fault     <= r_fault;
              i_rdata     <= r_data;
            end
            d_timeout <= r_to;
            mem_ce    <= 1'b1;
            state     <= RELEASE;
          end else begin
            wd_cnt <= wd_nxt;
          end
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: memory model plus
// transaction-level reference of grants, latency and responses.
module tb_mem_arbiter;
  import mem_pkg::*;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [2:0]  d_funct3 = '0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        i_ready, i_rsp_valid, i_fault;
  logic [31:0] i_rdata, d_rdata;
  logic        d_ready, d_rsp_valid, d_fault, d_timeout;
  logic        mem_ce, mem_memwrite;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_addr, mem_datain;
  logic [31:0] m_dout;
  logic        m_busy, m_valid, m_fault, m_act;
  int          m_cnt;
  int          cur_lat = 0;
  logic [31:0] mem_words [256];

  always #5 clk = ~clk;

  mem_arbiter #(
    .TIMEOUT_CYCLES(TO),
    .D_PRIORITY    (1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .i_req       (i_req),
    .i_addr      (i_addr),
    .i_ready     (i_ready),
    .i_rsp_valid (i_rsp_valid),
    .i_rdata     (i_rdata),
    .i_fault     (i_fault),
    .d_req       (d_req),
    .d_we        (d_we),
    .d_funct3    (d_funct3),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .d_ready     (d_ready),
    .d_rsp_valid (d_rsp_valid),
    .d_rdata     (d_rdata),
    .d_fault     (d_fault),
    .d_timeout   (d_timeout),
    .mem_ce      (mem_ce),
    .mem_funct3  (mem_funct3),
    .mem_addr    (mem_addr),
    .mem_datain  (mem_datain),
    .mem_memwrite(mem_memwrite),
    .mem_dataout (m_dout),
    .mem_busy    (m_busy),
    .mem_valid   (m_valid),
    .mem_fault   (m_fault)
  );

  function automatic logic [31:0] init_word(input int k);
    if (k == 'h40) return 32'hDEADBEEF;
    return 32'h1000_0000 | (k * 32'h0101);
  endfunction

  // Memory: samples request when ce first seen low, then after
  // cur_lat cycles completes. 0x009xxxxx faults, 0x00Axxxxx hangs busy.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_act <= 0; m_cnt <= 0; m_busy <= 0;
      m_valid <= 0; m_fault <= 0; m_dout <= 0;
      for (int k = 0; k < 256; k++) mem_words[k] <= init_word(k);
    end else if (mem_ce) begin
      m_act <= 0; m_cnt <= 0; m_busy <= 0;
      m_valid <= 0; m_fault <= 0; m_dout <= 0;
    end else if (!m_act) begin
      m_act <= 1; m_busy <= 1; m_cnt <= cur_lat;
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
    end else if (mem_addr[31:20] == 12'h00A) begin
      m_busy <= 1;
    end else if (mem_addr[31:20] == 12'h009) begin
      m_fault <= 1;
    end else if (mem_memwrite) begin
      mem_words[mem_addr[9:2]] <= mem_datain;
      m_busy <= 0;
    end else begin
      m_valid <= 1;
      m_dout <= mem_words[mem_addr[9:2]];
    end
  end

  int          checks = 0;
  int          errors = 0;
  int          step_n = 0;
  int          free_step = 0;
  int          rdy_step = 0;
  int          exp_lat = 0;
  int          lat_force = -1;
  bit          outstanding = 0;
  bit          rand_on = 0;
  port_t       exp_port = PORT_I;
  port_t       last_ref = PORT_I;
  bit          exp_fault = 0;
  bit          exp_to = 0;
  logic [31:0] exp_rdata = '0;
  logic [31:0] ref_i_rdata = '0;
  logic [31:0] ref_d_rdata = '0;
  logic [31:0] cap_addr = '0;
  logic [31:0] cap_din = '0;
  logic [2:0]  cap_f3 = '0;
  logic        cap_we = 1'b0;
  logic [31:0] ref_words [256];
  port_t       glog [$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 19);
    if (r < 2) return 32'h00A0_0000 | {22'd0, 8'($urandom_range(0, 255)), 2'b00};
    if (r < 5) return 32'h0090_0000 | {22'd0, 8'($urandom_range(0, 255)), 2'b00};
    return {22'd0, 8'($urandom_range(0, 255)), 2'b00};
  endfunction

  task automatic bench_reset_state();
    outstanding = 0;
    last_ref = PORT_I;
    ref_i_rdata = '0;
    ref_d_rdata = '0;
    cap_addr = '0; cap_din = '0; cap_f3 = '0; cap_we = 1'b0;
    for (int k = 0; k < 256; k++) ref_words[k] = init_word(k);
  endtask

  task automatic step();
    logic ei, ed, rsp_exp, ready_exp;
    port_t g;
    ei = i_req;
    ed = d_req;
    @(posedge clk);
    #1;
    step_n++;
    ready_exp = !outstanding && (step_n >= free_step) && (ei || ed);
    chk("any_ready", i_ready | d_ready, ready_exp);
    chk("both_ready", i_ready & d_ready, 0);
    if (i_ready | d_ready) begin
      g = d_ready ? PORT_D : PORT_I;
      chk("ready_req", d_ready ? ed : ei, 1);
      if (ei && ed)
        chk("rr_pick", g, (last_ref == PORT_D) ? PORT_I : PORT_D);
      last_ref = g;
      glog.push_back(g);
      cap_addr = (g == PORT_D) ? d_addr : i_addr;
      cap_we   = (g == PORT_D) && d_we;
      cap_f3   = (g == PORT_D) ? d_funct3 : 3'b010;
      cap_din  = (g == PORT_D) ? d_wdata : 32'd0;
      cur_lat  = (lat_force >= 0) ? lat_force : $urandom_range(0, 10);
      exp_port = g;
      exp_fault = 0; exp_to = 0; exp_rdata = '0;
      exp_lat = cur_lat + 3;
      if (cap_addr[31:20] == 12'h00A) begin
        exp_fault = 1; exp_to = 1; exp_lat = TO + 1;
      end else if (cap_addr[31:20] == 12'h009) begin
        exp_fault = 1;
      end else if (cap_we) begin
        ref_words[cap_addr[9:2]] = cap_din;
      end else begin
        exp_rdata = ref_words[cap_addr[9:2]];
      end
      outstanding = 1;
      rdy_step = step_n;
      if (g == PORT_D) d_req = 0;
      else i_req = 0;
    end
    rsp_exp = outstanding && (step_n == rdy_step + exp_lat);
    chk("i_rsp_valid", i_rsp_valid, rsp_exp && exp_port == PORT_I);
    chk("d_rsp_valid", d_rsp_valid, rsp_exp && exp_port == PORT_D);
    chk("i_fault", i_fault, rsp_exp && exp_port == PORT_I && exp_fault);
    chk("d_fault", d_fault, rsp_exp && exp_port == PORT_D && exp_fault);
    chk("d_timeout", d_timeout, rsp_exp && exp_to);
    if (rsp_exp) begin
      if (exp_port == PORT_I) ref_i_rdata = exp_rdata;
      else ref_d_rdata = exp_rdata;
      outstanding = 0;
      free_step = step_n + 2;
    end
    chk("i_rdata", i_rdata, ref_i_rdata);
    chk("d_rdata", d_rdata, ref_d_rdata);
    chk("mem_ce", mem_ce, !outstanding);
    chk("mem_addr", mem_addr, cap_addr);
    chk("mem_funct3", mem_funct3, cap_f3);
    chk("mem_datain", mem_datain, cap_din);
    chk("mem_memwrite", mem_memwrite, cap_we);
    if (rand_on) begin
      if (i_req && $urandom_range(0, 19) == 0) i_req = 0;
      else if (!i_req && $urandom_range(0, 2) == 0) begin
        i_req = 1;
        i_addr = rand_addr();
      end
      if (d_req && $urandom_range(0, 19) == 0) d_req = 0;
      else if (!d_req && $urandom_range(0, 2) == 0) begin
        d_req = 1;
        d_we = 1'($urandom_range(0, 1));
        d_funct3 = d_we ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 5));
        d_addr = rand_addr();
        d_wdata = $urandom;
      end
    end
  endtask

  task automatic wait_quiet(input int max);
    int n;
    n = 0;
    while ((i_req || d_req || outstanding) && n < max) begin
      step();
      n++;
    end
    chk("quiet", i_req || d_req || outstanding, 0);
  endtask

  task automatic d_op(input logic we, input logic [31:0] a,
                      input logic [31:0] wd);
    d_req = 1; d_we = we; d_funct3 = 3'b010;
    d_addr = a; d_wdata = wd;
  endtask

  initial begin
    bench_reset_state();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ce", mem_ce, 1);
    chk("rst_addr", mem_addr, 0);
    chk("rst_we", mem_memwrite, 0);
    chk("rst_ready", i_ready | d_ready, 0);
    chk("rst_rsp", i_rsp_valid | d_rsp_valid, 0);
    chk("rst_fault", i_fault | d_fault | d_timeout, 0);
    chk("rst_rdata", i_rdata | d_rdata, 0);
    reset = 1;
    free_step = step_n + 1;

    lat_force = 10;
    i_req = 1; i_addr = 32'h0000_0100;
    wait_quiet(60);
    chk("fetch_data", i_rdata, 32'hDEADBEEF);
    lat_force = -1;

    for (int r = 0; r < 2; r++) begin
      glog.delete();
      i_req = 1; i_addr = 32'h104;
      d_op(0, 32'h108, 0);
      wait_quiet(100);
      chk("sim_cnt", glog.size(), 2);
      if (glog.size() == 2) begin
        chk("sim_first", glog[0], PORT_D);
        chk("sim_second", glog[1], PORT_I);
      end
    end

    d_op(1, 32'h0080_0000, 32'hA);
    wait_quiet(60);
    chk("gpio_word", mem_words[0], 32'hA);
    d_op(0, 32'h0080_0000, 0);
    wait_quiet(60);
    chk("gpio_read", d_rdata, 32'hA);

    d_op(0, 32'h0090_0000, 0);
    wait_quiet(60);
    i_req = 1; i_addr = 32'h0000_0100;
    wait_quiet(60);
    chk("fetch_after_fault", i_rdata, 32'hDEADBEEF);

    d_op(0, 32'h00A0_0000, 0);
    wait_quiet(60);
    i_req = 1; i_addr = 32'h00A0_0010;
    wait_quiet(60);

    lat_force = 10;
    d_op(0, 32'h10, 0);
    for (int n = 0; n < 20 && !outstanding; n++) step();
    chk("rst_test_granted", outstanding, 1);
    repeat (3) step();
    reset = 0;
    #1;
    chk("midrst_ce", mem_ce, 1);
    chk("midrst_rsp", i_rsp_valid | d_rsp_valid, 0);
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("midrst_hold_rsp", i_rsp_valid | d_rsp_valid, 0);
      chk("midrst_hold_ce", mem_ce, 1);
    end
    i_req = 0; d_req = 0;
    bench_reset_state();
    lat_force = -1;
    reset = 1;
    free_step = step_n + 1;
    d_op(0, 32'h20, 0);
    wait_quiet(60);
    chk("post_rst_load", d_rdata, init_word('h08));

    rand_on = 1;
    repeat (1500) step();
    rand_on = 0;
    wait_quiet(100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
